// File: rtl/text_console_pkg.sv
// Shared geometry, control codes, FSM state encodings and cursor commands
// for the text console writer.
package text_console_pkg;

  localparam int unsigned COLS      = 80;
  localparam int unsigned ROWS      = 25;
  localparam int unsigned CELLS     = COLS * ROWS;
  localparam int unsigned BYTES     = 2 * CELLS;
  localparam int unsigned ROW_BYTES = 2 * COLS;

  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned CUR_W  = 11;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] ATTR_RST = 8'h17;
  localparam logic [DATA_W-1:0] CODE_CR  = 8'h0D;
  localparam logic [DATA_W-1:0] CODE_LF  = 8'h0A;
  localparam logic [DATA_W-1:0] CODE_BS  = 8'h08;
  localparam logic [DATA_W-1:0] CODE_FF  = 8'h0C;
  localparam logic [DATA_W-1:0] SPACE    = 8'h20;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_PUT_C       = 3'd1;
  localparam state_t ST_PUT_A       = 3'd2;
  localparam state_t ST_CLEAR       = 3'd3;
  localparam state_t ST_SCROLL_RD   = 3'd4;
  localparam state_t ST_SCROLL_WR   = 3'd5;
  localparam state_t ST_SCROLL_FILL = 3'd6;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_DEC,
    CMD_CR,
    CMD_LF,
    CMD_HOME
  } cur_cmd_t;

  // Blank-cell byte: space on the char byte, attribute on the attr byte.
  function automatic logic [DATA_W-1:0] fill_byte(input logic odd, input logic [DATA_W-1:0] at);
    return odd ? at : SPACE;
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Column/row counters and the linear cursor index driven to the video adapter.
module console_cursor
  import text_console_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  cur_cmd_t         cmd,
  output logic [CUR_W-1:0] cursor,
  output logic             last_row_c,
  output logic             wrap_scroll_c
);

  logic [COL_W-1:0] col, col_d;
  logic [ROW_W-1:0] row, row_d;

  assign last_row_c    = (row == ROW_W'(ROWS - 1));
  assign wrap_scroll_c = last_row_c && (col == COL_W'(COLS - 1));

  // Row never advances past the last row; the scroll supplies the new line.
  always_comb begin
    col_d = col;
    row_d = row;
    case (cmd)
      CMD_INC: begin
        if (col == COL_W'(COLS - 1)) begin
          col_d = '0;
          if (!last_row_c) row_d = row + ROW_W'(1);
        end else begin
          col_d = col + COL_W'(1);
        end
      end
      CMD_DEC:  if (col != '0) col_d = col - COL_W'(1);
      CMD_CR:   col_d = '0;
      CMD_LF:   if (!last_row_c) row_d = row + ROW_W'(1);
      CMD_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      cursor <= '0;
    end else begin
      col    <= col_d;
      row    <= row_d;
      cursor <= CUR_W'(row_d) * CUR_W'(COLS) + CUR_W'(col_d);
    end
  end

endmodule

// File: rtl/text_console.sv
// Byte-stream terminal writer: prints, clears and scrolls the 80x25
// char/attr video RAM and drives the adapter cursor.
module text_console
  import text_console_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] attr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CUR_W-1:0]  cursor,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] FIRST_SRC = ADDR_W'(ROW_BYTES);
  localparam logic [ADDR_W-1:0] FILL_BASE = ADDR_W'(BYTES - ROW_BYTES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d, pos_inc;
  logic [DATA_W-1:0]   attr_q, attr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_d, copy_q, copy_d, ready_d;
  cur_cmd_t            cmd;
  logic                last_row_c, wrap_scroll_c;
  logic [ADDR_W-1:0]   cur_addr;

  console_cursor u_cursor (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd           (cmd),
    .cursor        (cursor),
    .last_row_c    (last_row_c),
    .wrap_scroll_c (wrap_scroll_c)
  );

  assign cur_addr = {cursor, 1'b0};
  assign pos_inc  = pos_q + ADDR_W'(1);

  // Copy writes forward the read data the RAM returns in the write cycle.
  assign mem_wdata = copy_q ? mem_rdata : wdata_q;

  // State names the cycle whose memory outputs are being registered.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    attr_d  = attr_q;
    addr_d  = mem_address;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    copy_d  = 1'b0;
    ready_d = 1'b0;
    cmd     = CMD_NONE;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (in_valid && in_ready) begin
          ready_d = 1'b0;
          attr_d  = attr;
          case (in_data)
            CODE_CR: cmd = CMD_CR;
            CODE_BS: cmd = CMD_DEC;
            CODE_LF: begin
              if (last_row_c) begin
                state_d = ST_SCROLL_RD;
                pos_d   = FIRST_SRC;
                addr_d  = FIRST_SRC;
              end else begin
                cmd = CMD_LF;
              end
            end
            CODE_FF: begin
              state_d = ST_CLEAR;
              pos_d   = '0;
              addr_d  = '0;
              wdata_d = SPACE;
              we_d    = 1'b1;
            end
            default: begin
              state_d = ST_PUT_C;
              addr_d  = cur_addr;
              wdata_d = in_data;
              we_d    = 1'b1;
            end
          endcase
        end
      end
      ST_PUT_C: begin
        state_d = ST_PUT_A;
        addr_d  = {cursor, 1'b1};
        wdata_d = attr_q;
        we_d    = 1'b1;
      end
      ST_PUT_A: begin
        cmd = CMD_INC;
        if (wrap_scroll_c) begin
          state_d = ST_SCROLL_RD;
          pos_d   = FIRST_SRC;
          addr_d  = FIRST_SRC;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_CLEAR, ST_SCROLL_FILL: begin
        // mem_we low only in the cycle right after reset: issue address 0.
        if (!mem_we) begin
          addr_d  = pos_q;
          wdata_d = fill_byte(pos_q[0], attr_q);
          we_d    = 1'b1;
        end else if (pos_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cmd     = (state_q == ST_CLEAR) ? CMD_HOME : CMD_CR;
        end else begin
          pos_d   = pos_inc;
          addr_d  = pos_inc;
          wdata_d = fill_byte(pos_inc[0], attr_q);
          we_d    = 1'b1;
        end
      end
      ST_SCROLL_RD: begin
        state_d = ST_SCROLL_WR;
        addr_d  = pos_q - FIRST_SRC;
        we_d    = 1'b1;
        copy_d  = 1'b1;
      end
      ST_SCROLL_WR: begin
        if (pos_q == LAST_ADDR) begin
          state_d = ST_SCROLL_FILL;
          pos_d   = FILL_BASE;
          addr_d  = FILL_BASE;
          wdata_d = SPACE;
          we_d    = 1'b1;
        end else begin
          state_d = ST_SCROLL_RD;
          pos_d   = pos_inc;
          addr_d  = pos_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      pos_q       <= '0;
      attr_q      <= ATTR_RST;
      mem_address <= '0;
      wdata_q     <= '0;
      mem_we      <= 1'b0;
      copy_q      <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      attr_q      <= attr_d;
      mem_address <= addr_d;
      wdata_q     <= wdata_d;
      mem_we      <= we_d;
      copy_q      <= copy_d;
      in_ready    <= ready_d;
      busy        <= ~ready_d;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a RAM model plus a write scoreboard fed
// from a reference screen model, checked on every falling clock edge.
module tb_text_console;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] attr = 8'h00;
  logic [11:0] mem_address;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic [10:0] cursor;
  logic       busy;

  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [19:0] exp_q[$];
  int col = 0;
  int row = 0;
  int errors = 0;
  int checks = 0;

  text_console dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .attr        (attr),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .cursor      (cursor),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Video RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
    mem_rdata <= ram[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [19:0] e;
    @(negedge clock);
    if (mem_we === 1'b1) begin
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("mem_write", {12'h0, mem_address, mem_wdata}, {12'h0, e});
    end
  endtask

  task automatic push_write(input logic [11:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic push_fill(input int first, input logic [7:0] a);
    for (int i = first; i < 4000; i++) push_write(12'(i), i[0] ? a : 8'h20);
  endtask

  task automatic push_scroll(input logic [7:0] a);
    for (int s = 160; s < 4000; s++) push_write(12'(s - 160), ref_mem[12'(s)]);
    push_fill(3840, a);
  endtask

  task automatic wait_ready(input int n0, input int lat, input string tag);
    int n;
    n = n0;
    while (in_ready !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(lat));
  endtask

  // Drive one byte, predicting its writes, latency and resulting cursor.
  task automatic send(input logic [7:0] d, input logic [7:0] a, input string tag);
    int lat;
    lat = 2;
    case (d)
      8'h0D: col = 0;
      8'h08: if (col > 0) col--;
      8'h0A: begin
        if (row < 24) row++;
        else begin
          push_scroll(a);
          col = 0;
          lat = 7841;
        end
      end
      8'h0C: begin
        push_fill(0, a);
        col = 0;
        row = 0;
        lat = 4001;
      end
      default: begin
        push_write(12'((row * 80 + col) * 2), d);
        push_write(12'((row * 80 + col) * 2 + 1), a);
        lat = 3;
        col++;
        if (col == 80) begin
          col = 0;
          if (row < 24) row++;
          else begin
            push_scroll(a);
            lat = 7843;
          end
        end
      end
    endcase
    in_data  = d;
    attr     = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ready(1, lat, {tag, "_latency"});
    check({tag, "_cursor"}, 32'(cursor), 32'(row * 80 + col));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_address", 32'(mem_address), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);

    push_fill(0, 8'h17);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_ready(0, 4001, "power_on_clear");
    check("power_on_cursor", 32'(cursor), 32'd0);
    check("power_on_busy", 32'(busy), 32'd0);
    check("power_on_drained", 32'(exp_q.size()), 32'd0);

    send(8'h41, 8'h1E, "print_A");
    check("ram0_A", 32'(ram[0]), 32'h41);
    check("ram1_attr", 32'(ram[1]), 32'h1E);

    send(8'h0D, 8'h07, "cr_home");
    for (int i = 0; i < 80; i++) send(8'h78, 8'h07, "print_x");
    send(8'h0D, 8'h07, "cr_row1");
    send(8'h0A, 8'h07, "lf_row2");
    send(8'h08, 8'h07, "bs_col0");

    send(8'h0C, 8'h70, "form_feed");
    check("ff_ram2", 32'(ram[2]), 32'h20);
    check("ff_ram3999", 32'(ram[3999]), 32'h70);

    send(8'h0A, 8'h07, "lf_seed");
    send(8'h51, 8'h1E, "print_Q");
    check("ram160_Q", 32'(ram[160]), 32'h51);
    send(8'h0D, 8'h07, "cr_seed");
    for (int i = 0; i < 23; i++) send(8'h0A, 8'h07, "lf_down");
    send(8'h0A, 8'h07, "lf_scroll");
    check("scroll_ram0_Q", 32'(ram[0]), 32'h51);
    check("scroll_fill_char", 32'(ram[3840]), 32'h20);
    check("scroll_fill_attr", 32'(ram[3999]), 32'h07);

    for (int i = 0; i < 80; i++) send(8'h7A, 8'h2A, "print_z");
    check("wrap_scroll_row23", 32'(ram[3680]), 32'h7A);
    check("wrap_scroll_fill", 32'(ram[3841]), 32'h2A);

    // Start another scroll from the last row, then cut it short with reset.
    push_scroll(8'h07);
    in_data  = 8'h0A;
    attr     = 8'h07;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (200) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_address", 32'(mem_address), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_cursor", 32'(cursor), 32'd0);
    exp_q.delete();
    col = 0;
    row = 0;
    push_fill(0, 8'h17);
    repeat (3) tick();
    reset_n = 1'b1;
    wait_ready(0, 4001, "reclear_latency");
    check("reclear_cursor", 32'(cursor), 32'd0);
    check("reclear_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
